// File: rtl/atm_port_ctrl_pkg.sv
// Shared constants and state encodings for the ATM port controller and its DOS/stall unit.
package atm_port_ctrl_pkg;

   // 7FFD is partially decoded: only za[15] and za[1] must be low.
   localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;
   localparam logic [15:0] PORT_EFF7      = 16'hEFF7;
   localparam logic [7:0]  PORT_77_LO     = 8'h77;
   localparam logic [7:0]  PORT_F7_LO     = 8'hF7;

   localparam logic       PAGER_OFF_RST  = 1'b1;
   localparam logic       PENT_ROM_RST   = 1'b0;
   localparam logic [5:0] PENT_PAGE_RST  = 6'h00;
   localparam logic       PENT_RAM0_RST  = 1'b0;
   localparam logic       PENT_1M_RST    = 1'b0;
   localparam logic       PENT_LOCK_RST  = 1'b0;

   typedef enum logic {WR_IDLE, WR_WAIT} wr_state_t;
   typedef enum logic {DS_IDLE, DS_STALL} ds_state_t;

endpackage

// File: rtl/atm_port_ctrl_dos_stall.sv
// DOS flag owner: merges per-window enter/exit strobes and stalls the Z80 clock
// for STALL_LEN fclk cycles whenever DOS ROM switches in.
module atm_dos_stall
   import atm_port_ctrl_pkg::*;
#(
   parameter int unsigned STALL_LEN = 4
) (
   input  logic       fclk,
   input  logic       arst_n,
   input  logic [3:0] dos_turn_on,
   input  logic [3:0] dos_turn_off,
   output logic       dos,
   output logic       zclk_stall
);

   ds_state_t  state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       dos_q, dos_d;
   logic       stall_q, stall_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dos_d   = dos_q;
      stall_d = stall_q;
      case (state_q)
         DS_IDLE: begin
            // Turn-on has priority when both arrive together.
            if ((|dos_turn_on) && !dos_q) begin
               dos_d   = 1'b1;
               cnt_d   = 3'(STALL_LEN - 1);
               stall_d = 1'b1;
               state_d = DS_STALL;
            end else if ((|dos_turn_off) && dos_q) begin
               dos_d = 1'b0;
            end
         end
         DS_STALL: begin
            if (cnt_q == 3'd0) begin
               stall_d = 1'b0;
               state_d = DS_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge fclk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= DS_IDLE;
         cnt_q   <= 3'd0;
         dos_q   <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dos_q   <= dos_d;
         stall_q <= stall_d;
      end
   end

   assign dos        = dos_q;
   assign zclk_stall = stall_q;

endmodule

// File: rtl/atm_port_ctrl.sv
// Global ATM paging state: decodes Z80 writes to 7FFD/EFF7/xx77/xxF7 once per
// I/O cycle and hosts the DOS/stall unit shared by all four window pagers.
module atm_port_ctrl
   import atm_port_ctrl_pkg::*;
#(
   parameter int unsigned STALL_LEN = 4
) (
   input  logic        fclk,
   input  logic        arst_n,
   input  logic        zpos,
   input  logic        zneg,
   input  logic [15:0] za,
   input  logic [7:0]  zd,
   input  logic        iorq_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic [3:0]  dos_turn_on,
   input  logic [3:0]  dos_turn_off,
   output logic        atm_xxF7_wr,
   output logic        pager_off,
   output logic        pent1m_ROM,
   output logic [5:0]  pent1m_page,
   output logic        pent1m_ram0_0,
   output logic        pent1m_1m_on,
   output logic        dos,
   output logic        zclk_stall
);

   wr_state_t  wr_state_q, wr_state_d;
   logic       pager_off_q, pager_off_d;
   logic       rom_q, rom_d;
   logic [5:0] page_q, page_d;
   logic       ram0_q, ram0_d;
   logic       onem_q, onem_d;
   logic       lock_q, lock_d;
   logic       xxf7_wr_q, xxf7_wr_d;

   logic z_edge, io_wr, accept;
   logic hit_7ffd, hit_eff7, hit_77, hit_f7;

   // zpos and zneg never coincide on a real Z80 clock; zneg only vetoes a malformed edge.
   assign z_edge = zpos & ~zneg;
   assign io_wr  = ~iorq_n & ~wr_n & m1_n;
   assign accept = (wr_state_q == WR_IDLE) && z_edge && io_wr;

   assign hit_7ffd = ((za & PORT_7FFD_MASK) == 16'h0000) && (!lock_q || onem_q);
   assign hit_eff7 = (za == PORT_EFF7) && !dos;
   assign hit_77   = (za[7:0] == PORT_77_LO) && dos;
   assign hit_f7   = (za[7:0] == PORT_F7_LO) && dos;

   always_comb begin
      wr_state_d  = wr_state_q;
      pager_off_d = pager_off_q;
      rom_d       = rom_q;
      page_d      = page_q;
      ram0_d      = ram0_q;
      onem_d      = onem_q;
      lock_d      = lock_q;
      xxf7_wr_d   = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (accept) begin
               wr_state_d = WR_WAIT;
               if (hit_7ffd) begin
                  rom_d = zd[4];
                  if (onem_q) begin
                     page_d = {zd[5], zd[7:6], zd[2:0]};
                  end else begin
                     page_d = {3'b000, zd[2:0]};
                     lock_d = zd[5];
                  end
               end
               if (hit_eff7) begin
                  onem_d = ~zd[2];
                  ram0_d = zd[3];
               end
               if (hit_77) begin
                  pager_off_d = ~za[8];
               end
               xxf7_wr_d = hit_f7;
            end
         end
         WR_WAIT: begin
            // Hold off until the I/O cycle ends so wait states cannot re-trigger.
            if (z_edge && iorq_n) begin
               wr_state_d = WR_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge fclk or negedge arst_n) begin
      if (!arst_n) begin
         wr_state_q  <= WR_IDLE;
         pager_off_q <= PAGER_OFF_RST;
         rom_q       <= PENT_ROM_RST;
         page_q      <= PENT_PAGE_RST;
         ram0_q      <= PENT_RAM0_RST;
         onem_q      <= PENT_1M_RST;
         lock_q      <= PENT_LOCK_RST;
         xxf7_wr_q   <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         pager_off_q <= pager_off_d;
         rom_q       <= rom_d;
         page_q      <= page_d;
         ram0_q      <= ram0_d;
         onem_q      <= onem_d;
         lock_q      <= lock_d;
         xxf7_wr_q   <= xxf7_wr_d;
      end
   end

   atm_dos_stall #(
      .STALL_LEN (STALL_LEN)
   ) u_dos_stall (
      .fclk         (fclk),
      .arst_n       (arst_n),
      .dos_turn_on  (dos_turn_on),
      .dos_turn_off (dos_turn_off),
      .dos          (dos),
      .zclk_stall   (zclk_stall)
   );

   assign atm_xxF7_wr   = xxf7_wr_q;
   assign pager_off     = pager_off_q;
   assign pent1m_ROM    = rom_q;
   assign pent1m_page   = page_q;
   assign pent1m_ram0_0 = ram0_q;
   assign pent1m_1m_on  = onem_q;

endmodule
